// File: rtl/pulse_stretcher.sv
// pulse_stretcher
// Stretches single-cycle event strobes into visible blinks: ON_CYCLES high,
// then a mandatory GAP_CYCLES low gap. One down-counter serves both phases.
//
// Build option: define PULSE_STRETCHER_QUEUE_EN to queue strobes that arrive
// mid-blink (up to QUEUE_DEPTH) and replay them back to back. With the macro
// undefined there is no queue: a strobe during ON retriggers (extends) the
// high phase, and a strobe during the gap is dropped and flagged.
//
// All outputs come straight from flops; pulse_in never reaches an output
// combinationally.

module pulse_stretcher #(
    parameter int ON_CYCLES   = 5_000_000,
    parameter int GAP_CYCLES  = 5_000_000,
    parameter int QUEUE_DEPTH = 15
) (
    input  logic                               clk,
    input  logic                               reset_n,
    input  logic                               pulse_in,
    output logic                               level_out,
    output logic                               busy,
    output logic [$clog2(QUEUE_DEPTH+1)-1:0]   pending,
    output logic                               overflow
);

    // Timer only ever holds a reload value minus one, so it needs to cover
    // max(ON_CYCLES, GAP_CYCLES)-1.
    localparam int MAX_CYC = (ON_CYCLES > GAP_CYCLES) ? ON_CYCLES : GAP_CYCLES;
    localparam int TMR_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
    localparam int PEND_W  = $clog2(QUEUE_DEPTH + 1);

    localparam logic [TMR_W-1:0]  ON_LOAD  = TMR_W'(ON_CYCLES - 1);
    localparam logic [TMR_W-1:0]  GAP_LOAD = TMR_W'(GAP_CYCLES - 1);
    localparam logic [PEND_W-1:0] PEND_MAX = PEND_W'(QUEUE_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ON   = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    state_t              r_state;
    logic [TMR_W-1:0]    r_timer;
    logic [PEND_W-1:0]   r_pending;
    logic                r_level;
    logic                r_busy;
    logic                r_overflow;

    logic                w_tmr_zero;
    logic                w_q_full;

    assign w_tmr_zero = (r_timer == '0);
    assign w_q_full   = (r_pending == PEND_MAX);

    // Blink FSM: state, timer, queue count and all outputs update together so
    // level_out/busy are exact registered images of the state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= S_IDLE;
            r_timer    <= '0;
            r_pending  <= '0;
            r_level    <= 1'b0;
            r_busy     <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            // overflow is a one-cycle strobe; only a drop this cycle raises it
            r_overflow <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (pulse_in) begin
                        r_state <= S_ON;
                        r_timer <= ON_LOAD;
                        r_level <= 1'b1;
                        r_busy  <= 1'b1;
                    end
                end

                S_ON: begin
`ifdef PULSE_STRETCHER_QUEUE_EN
                    // Strobes during ON are parked; saturate and flag when full.
                    if (pulse_in) begin
                        if (!w_q_full)
                            r_pending <= r_pending + 1'b1;
                        else
                            r_overflow <= 1'b1;
                    end
                    if (w_tmr_zero) begin
                        r_state <= S_GAP;
                        r_timer <= GAP_LOAD;
                        r_level <= 1'b0;
                    end else begin
                        r_timer <= r_timer - 1'b1;
                    end
`else
                    // Retrigger: a fresh strobe restarts the full high phase,
                    // taking priority over the phase ending this cycle.
                    if (pulse_in) begin
                        r_timer <= ON_LOAD;
                    end else if (w_tmr_zero) begin
                        r_state <= S_GAP;
                        r_timer <= GAP_LOAD;
                        r_level <= 1'b0;
                    end else begin
                        r_timer <= r_timer - 1'b1;
                    end
`endif
                end

                S_GAP: begin
                    if (!w_tmr_zero) begin
                        r_timer <= r_timer - 1'b1;
`ifdef PULSE_STRETCHER_QUEUE_EN
                        if (pulse_in) begin
                            if (!w_q_full)
                                r_pending <= r_pending + 1'b1;
                            else
                                r_overflow <= 1'b1;
                        end
`else
                        // No queue: a strobe inside the gap cannot be honoured.
                        if (pulse_in)
                            r_overflow <= 1'b1;
`endif
                    end else if (pulse_in) begin
                        // Strobe exactly at gap expiry starts the next blink
                        // directly; it never touches the queue.
                        r_state <= S_ON;
                        r_timer <= ON_LOAD;
                        r_level <= 1'b1;
`ifdef PULSE_STRETCHER_QUEUE_EN
                    end else if (r_pending != '0) begin
                        // Replay the oldest queued strobe with no idle cycle.
                        r_state   <= S_ON;
                        r_timer   <= ON_LOAD;
                        r_level   <= 1'b1;
                        r_pending <= r_pending - 1'b1;
`endif
                    end else begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                    r_timer <= '0;
                    r_level <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign level_out = r_level;
    assign busy      = r_busy;
    assign pending   = r_pending;
    assign overflow  = r_overflow;

endmodule

// File: tb/tb_pulse_stretcher.sv
// Bench for pulse_stretcher (ON=4, GAP=3, QUEUE_DEPTH=2). A behavioural model
// tracks remaining cycles per phase; each driven cycle pushes the expected
// post-edge outputs to a scoreboard that is popped after the edge. Expectations
// follow PULSE_STRETCHER_QUEUE_EN the same way the design build does.

module tb_pulse_stretcher;

    localparam int ON = 4;
    localparam int GAP = 3;
    localparam int QD = 2;
    localparam int PW = $clog2(QD + 1);

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          pulse_in = 1'b0;
    logic          level_out;
    logic          busy;
    logic [PW-1:0] pending;
    logic          overflow;

    pulse_stretcher #(
        .ON_CYCLES  (ON),
        .GAP_CYCLES (GAP),
        .QUEUE_DEPTH(QD)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .pulse_in (pulse_in),
        .level_out(level_out),
        .busy     (busy),
        .pending  (pending),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        int lvl;
        int bsy;
        int pnd;
        int ovf;
    } exp_t;

    exp_t sb[$];

    int checks = 0;
    int fails  = 0;

    // model: 0 idle, 1 on, 2 gap; m_left = cycles left in current phase
    int m_st = 0;
    int m_left = 0;
    int m_pnd = 0;
    int m_ovf = 0;

    int d_rises = 0;
    int d_ovfs  = 0;
    logic d_prev_lvl = 1'b0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic model_step(input bit p);
        exp_t e;
        m_ovf = 0;
        case (m_st)
            0: if (p) begin m_st = 1; m_left = ON; end
            1: begin
`ifdef PULSE_STRETCHER_QUEUE_EN
                if (p) begin
                    if (m_pnd < QD) m_pnd++;
                    else m_ovf = 1;
                end
                if (m_left == 1) begin m_st = 2; m_left = GAP; end
                else m_left--;
`else
                if (p) m_left = ON;
                else if (m_left == 1) begin m_st = 2; m_left = GAP; end
                else m_left--;
`endif
            end
            default: begin
                if (m_left == 1) begin
                    if (p) begin m_st = 1; m_left = ON; end
                    else if (m_pnd > 0) begin m_pnd--; m_st = 1; m_left = ON; end
                    else m_st = 0;
                end else begin
                    m_left--;
`ifdef PULSE_STRETCHER_QUEUE_EN
                    if (p) begin
                        if (m_pnd < QD) m_pnd++;
                        else m_ovf = 1;
                    end
`else
                    if (p) m_ovf = 1;
`endif
                end
            end
        endcase
        e.lvl = (m_st == 1) ? 1 : 0;
        e.bsy = (m_st != 0) ? 1 : 0;
        e.pnd = m_pnd;
        e.ovf = m_ovf;
        sb.push_back(e);
    endtask

    // Drive one cycle (called just after an active edge), then check after
    // the following edge.
    task automatic cyc(input bit p);
        exp_t e;
        pulse_in = p;
        model_step(p);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            chk("sb_underflow", 1, 0);
        end else begin
            e = sb.pop_front();
            chk("level_out", {31'd0, level_out}, e.lvl);
            chk("busy", {31'd0, busy}, e.bsy);
            chk("pending", 32'(pending), e.pnd);
            chk("overflow", {31'd0, overflow}, e.ovf);
        end
        if (level_out === 1'b1 && d_prev_lvl !== 1'b1) d_rises++;
        if (overflow === 1'b1) d_ovfs++;
        d_prev_lvl = level_out;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0);
    endtask

    // Asynchronous reset between edges; outputs must clear with no clock.
    task automatic do_reset();
        pulse_in = 1'b0;
        #1;
        reset_n = 1'b0;
        #1;
        chk("rst_level", {31'd0, level_out}, 0);
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_pending", 32'(pending), 0);
        chk("rst_overflow", {31'd0, overflow}, 0);
        m_st = 0; m_left = 0; m_pnd = 0; m_ovf = 0;
        d_prev_lvl = 1'b0;
        #1;
        reset_n = 1'b1;
    endtask

    int r0, o0;

    initial begin
        // reset state
        #2;
        chk("init_level", {31'd0, level_out}, 0);
        chk("init_busy", {31'd0, busy}, 0);
        chk("init_pending", 32'(pending), 0);
        chk("init_overflow", {31'd0, overflow}, 0);
        @(posedge clk);
        #2;
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // single pulse
        r0 = d_rises; o0 = d_ovfs;
        cyc(1'b1);
        idle(10);
        chk("single_blinks", d_rises - r0, 1);
        chk("single_ovf", d_ovfs - o0, 0);

        // back-to-back pulses
        r0 = d_rises; o0 = d_ovfs;
        cyc(1'b1); cyc(1'b1); cyc(1'b1);
        idle(25);
`ifdef PULSE_STRETCHER_QUEUE_EN
        chk("b2b_blinks", d_rises - r0, 3);
`else
        chk("b2b_blinks", d_rises - r0, 1);
`endif
        chk("b2b_ovf", d_ovfs - o0, 0);

        // overflow
        r0 = d_rises; o0 = d_ovfs;
        cyc(1'b1); cyc(1'b1); cyc(1'b1); cyc(1'b1);
        idle(25);
`ifdef PULSE_STRETCHER_QUEUE_EN
        chk("ovf_blinks", d_rises - r0, 3);
        chk("ovf_count", d_ovfs - o0, 1);
`else
        chk("ovf_blinks", d_rises - r0, 1);
        chk("ovf_count", d_ovfs - o0, 0);
`endif

        // pulse exactly at gap expiry (edge 7)
        r0 = d_rises;
        cyc(1'b1);
        idle(6);
        cyc(1'b1);
        chk("gapexp_level", {31'd0, level_out}, 1);
        chk("gapexp_pending", 32'(pending), 0);
        idle(10);
        chk("gapexp_blinks", d_rises - r0, 2);

        // reset mid-ON with a queued strobe
        cyc(1'b1); cyc(1'b1); cyc(1'b0);
        do_reset();
        r0 = d_rises;
        cyc(1'b1);
        idle(10);
        chk("postrst_blinks", d_rises - r0, 1);

        // retrigger at edge 2, then a strobe inside the gap at edge 7
        r0 = d_rises; o0 = d_ovfs;
        cyc(1'b1); cyc(1'b0); cyc(1'b1);
        idle(4);
        cyc(1'b1);
        idle(20);
`ifdef PULSE_STRETCHER_QUEUE_EN
        chk("retrig_blinks", d_rises - r0, 3);
        chk("retrig_ovf", d_ovfs - o0, 0);
`else
        chk("retrig_blinks", d_rises - r0, 1);
        chk("retrig_ovf", d_ovfs - o0, 1);
`endif

        // random traffic against the model
        for (int i = 0; i < 300; i++) cyc(($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0);
        idle(30);
        chk("final_busy", {31'd0, busy}, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule

// File: doc/pulse_stretcher.md
# pulse_stretcher

Turns single-cycle event strobes (e.g. `p_edge`/`n_edge` from the button edge detector) back into human-visible level waveforms. Each accepted strobe becomes one fixed-length high pulse on `level_out` followed by a mandatory low gap, so consecutive events show up as distinct LED blinks. Strobes that arrive while a blink is in progress are queued and replayed in order. It sits between the button conditioning logic and the LED drivers.

## Interface
- `ON_CYCLES`, default 5_000_000: length of the high phase in clk cycles (50 ms at 100 MHz); must be ≥1.
- `GAP_CYCLES`, default 5_000_000: length of the low gap after each high phase; must be ≥1.
- `QUEUE_DEPTH`, default 15: maximum number of pending strobes; must be ≥1.
- `clk`  in  1  system clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `pulse_in`  in  1  event strobe, synchronous to clk; each high cycle counts as one event.
- `level_out`  out  1  stretched output level, registered.
- `busy`  out  1  high while in ON or GAP.
- `pending`  out  $clog2(QUEUE_DEPTH+1)  number of queued, not yet started blinks.
- `overflow`  out  1  one-cycle strobe when an event is dropped.

## Operation
- States: IDLE, ON, GAP. There is one down-counter `timer`, wide enough for max(ON_CYCLES, GAP_CYCLES)-1.
- IDLE: if `pulse_in`=1, go to ON with timer=ON_CYCLES-1.
- ON: when timer≠0, decrement it. When timer=0, go to GAP with timer=GAP_CYCLES-1.
- GAP: when timer≠0, decrement it. When timer=0:
  - if `pulse_in`=1, go to ON; the pulse is consumed directly and `pending` is unchanged;
  - else if `pending`>0, go to ON and decrement `pending`;
  - else go to IDLE.
- `pulse_in` in ON, or in GAP with timer≠0: if `pending`<QUEUE_DEPTH, increment `pending`; otherwise drop the event and set `overflow`=1 for the next cycle.
- `pending` saturates. It never wraps and never goes below 0.
- `level_out` = (state==ON), registered alongside the state. `busy` = (state≠IDLE).
- Outputs are all registered. There is no combinational path from `pulse_in` to any output.

## Timing
- Reset (asynchronous, applies immediately, including mid-ON or mid-GAP): state=IDLE, timer=0, `level_out`=0, `busy`=0, `pending`=0, `overflow`=0. No blink in progress survives reset.
- If `pulse_in` is sampled high at edge k in IDLE, then `level_out` is high from edge k to edge k+ON_CYCLES (exactly ON_CYCLES cycles).
- `level_out` is then low for exactly GAP_CYCLES cycles. `busy` is high for ON_CYCLES+GAP_CYCLES cycles per blink.
- Queued blinks start on the edge the GAP expires. There is no IDLE cycle between them, so the period is ON_CYCLES+GAP_CYCLES.
- `overflow` is high for the single cycle after the dropped event's edge.

## Configuration
- `PULSE_STRETCHER_QUEUE_EN` defined: queueing behaves as described above.
- `PULSE_STRETCHER_QUEUE_EN` undefined: no queue.
  - `pending` is tied to 0.
  - `pulse_in` in ON reloads timer=ON_CYCLES-1, which extends the high phase (retrigger).
  - `pulse_in` in GAP with timer≠0 is dropped and strobes `overflow`.
  - `pulse_in` at GAP expiry starts ON as before.

## Test plan
Use ON_CYCLES=4, GAP_CYCLES=3, QUEUE_DEPTH=2, with the macro defined unless a scenario says otherwise.
- **Single pulse:** single `pulse_in` at edge 0 → `level_out` high for edges 0–4 (4 cycles), `busy` high for edges 0–7, IDLE from edge 7, `pending` stays 0.
- **Back-to-back pulses:** pulses at edges 0, 1, 2 → `pending` goes to 1 then 2; `level_out` high in windows [0,4), [7,11), [14,18); `pending` drops to 1 at edge 7 and to 0 at edge 14; `overflow` is never set.
- **Overflow:** pulses at edges 0, 1, 2, 3 → the pulse at edge 3 is dropped, `overflow`=1 for one cycle after edge 3, exactly 3 blinks occur.
- **Pulse at GAP expiry:** pulse at edge 0, then a pulse at edge 7 (GAP expiry) with `pending`=0 → ON resumes at edge 7 with no IDLE cycle, `pending` stays 0.
- **Reset mid-blink:** `reset_n` low at cycle 2 of ON with `pending`=1 → `level_out`, `busy`, `pending` all 0 immediately, with no clock needed; after release, one pulse produces a normal 4-high/3-low blink.
- **Macro undefined (retrigger):** pulses at edges 0 and 2 → `level_out` high for edges 0–6 (6 cycles), then low for 3 cycles; a pulse during GAP strobes `overflow` and produces no blink.
